mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
Round-robin arbiter/controller that shares one 8:1 single-bit mux between 8 requesters. It decides which requester owns the mux, drives the 3-bit mux select, and publishes a one-hot grant. Ownership is held until the owner releases or a hold-time limit expires, so no requester can starve the others. Sits directly in front of the 8:1 mux select inputs in the datapath.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant; 0 = unlimited (released only by dropping req).
CNT_W, $clog2(MAX_HOLD+1) (min 1), hold-counter width; derived, not overridden.

Ports:
clk  input  1  single system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
en  input  1  arbitration enable; 0 forces release and blocks new grants.
req  input  8  request vector, bit i = requester i wants mux input Di.
grant  output  8  one-hot registered grant; 8'h00 when nobody owns the mux.
sel  output  3  mux select = index of current owner; drives the mux select lines (sel[2] MSB).
grant_valid  output  1  1 while grant is non-zero.
hold_cnt  output  CNT_W  cycles the current owner has held the grant (0 on the first grant cycle).

Behaviour:
- Reset (rst_n=0 at edge): grant=8'h00, sel=3'd0, grant_valid=0, hold_cnt=0, state=IDLE, priority pointer last=3'd7 (so requester 0 has top priority first). Reset overrides everything, including mid-grant.
- States: IDLE (no owner), BUSY (owner = sel).
- Winner function: first set bit of req scanning last+1, last+2, ... wrapping 7->0; the requester at index last is checked last.
- IDLE: if en=1 and req!=0 at edge -> grant=onehot(winner), sel=winner, hold_cnt=0, state=BUSY. Latency req->grant = 1 cycle. Otherwise stay IDLE; sel holds its previous value.
- BUSY, release conditions evaluated at each edge: (a) req[sel]=0, (b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, (c) en=0.
- No release: grant/sel unchanged, hold_cnt increments (saturates at all-ones when MAX_HOLD=0).
- Release by (a) or (b): last<=sel; winner is computed from req with the updated pointer in the same edge. If a winner exists -> grant switches directly to it (back-to-back, no idle cycle), hold_cnt=0, stay BUSY. If none -> grant=0, state=IDLE.
- On timeout (b), the old owner is lowest priority. It is re-granted only if it is the sole requester, and it then restarts with hold_cnt=0.
- Release by (c): last<=sel, grant=0, state=IDLE next cycle regardless of req.
- grant is always zero or one-hot. grant_valid==(grant!=0). When grant_valid=1, sel==index of the set grant bit.
- Requests arriving mid-grant do not pre-empt the owner.
- req changes on non-owner bits while BUSY have no effect until the next release.
- Pointer updates only on release, never on grant.

Test Plan:
1. Hold rst_n=0 two cycles with req=8'hFF, en=1 -> grant=8'h00, sel=0, grant_valid=0, hold_cnt=0. Release reset -> grant=8'h01, sel=0 on the next edge.
2. en=1, single req=8'h08 raised at cycle t, dropped at t+5 -> grant=8'h08, sel=3 at t+1..t+5, hold_cnt 0..4, grant=8'h00 at t+6.
3. MAX_HOLD=4, req=8'hFF constant -> sel sequence 0,1,...,7,0, each held exactly 4 cycles, no idle cycles between owners.
4. Owner 7 holding, req=8'h81, owner drops req[7] -> next grant=8'h01 immediately (wrap). With req=8'h80 only and timeout -> 7 re-granted, hold_cnt restarts at 0.
5. Owner 2 holding, en=0 for 3 cycles -> grant=0 one cycle after en falls. en=1 with req=8'h06 -> grant=8'h02? No: pointer=2, so grant=8'h04?? Resolved: req bits 1,2 set, scan from 3 wraps to 1 -> grant=8'h02, sel=1.
6. Synchronous reset asserted while owner 5 holds -> all outputs cleared on that edge. After release with req=8'hFF -> requester 0 granted first.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin owner selection for one shared 8:1 single-bit mux. The arbiter
// decides which of eight requesters owns the mux, drives the 3-bit mux select
// and publishes a registered one-hot grant. An owner keeps the mux until it
// drops its request, the hold-time limit expires, or arbitration is disabled.
// The priority pointer only moves on release, so the releasing owner becomes
// the lowest-priority candidate for the very next decision.
//
// Handshake: req[i] is a level request. grant[i] is asserted one cycle after a
// winning req[i] is seen and stays asserted while req[i] stays high, up to the
// hold limit. A requester that drops req[i] loses the grant on the next edge.
// There is no back-pressure; the mux select follows grant directly.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   rst_n        in   synchronous active-low reset
//   en           in   arbitration enable; low forces release, blocks grants
//   req[7:0]     in   request vector, bit i = requester i wants mux input Di
//   grant[7:0]   out  registered one-hot grant, 8'h00 when the mux is unowned
//   sel[2:0]     out  mux select = index of the current owner
//   grant_valid  out  high while grant is non-zero
//   hold_cnt     out  cycles the current owner has held (0 on first cycle)
//   dbg_state    out  FSM state (0 = IDLE, 1 = BUSY)
//   dbg_last[2:0] out priority pointer (index of the last released owner)
// -----------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       req,
  output logic [7:0]       grant,
  output logic [2:0]       sel,
  output logic             grant_valid,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             dbg_state,
  output logic [2:0]       dbg_last
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Hold count value on the owner's final permitted cycle. Unused when
  // MAX_HOLD is 0 (the timeout term is then constant false).
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       sel_q,   sel_d;
  logic [2:0]       last_q,  last_d;
  logic [CNT_W-1:0] hold_q,  hold_d;

  // Winner search: first set bit of r scanning ptr+1, ptr+2, ... wrapping
  // 7->0, with ptr itself checked last. The loop runs from the farthest
  // candidate to the nearest so the nearest set bit is the final assignment.
  // Result is {found, index}.
  function automatic logic [3:0] pick_winner(input logic [7:0] r,
                                             input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr + 3'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic [3:0] win_idle;   // winner against the current pointer
  logic [3:0] win_rel;    // winner against the pointer after release (= sel)
  logic       owner_drop;
  logic       timeout;

  assign win_idle   = pick_winner(req, last_q);
  assign win_rel    = pick_winner(req, sel_q);
  assign owner_drop = ~req[sel_q];
  assign timeout    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;

    unique case (state_q)
      S_IDLE: begin
        // sel keeps its previous value while nobody owns the mux.
        if (en && win_idle[3]) begin
          state_d = S_BUSY;
          grant_d = 8'h01 << win_idle[2:0];
          sel_d   = win_idle[2:0];
          hold_d  = '0;
        end
      end

      S_BUSY: begin
        if (!en) begin
          // Disable wins over everything else: release with no re-grant.
          state_d = S_IDLE;
          grant_d = 8'h00;
          last_d  = sel_q;
          hold_d  = '0;
        end else if (owner_drop || timeout) begin
          // Pointer moves to the old owner, so the search below already
          // treats it as lowest priority. A sole requester that timed out is
          // therefore re-granted with a fresh hold count.
          last_d = sel_q;
          if (win_rel[3]) begin
            grant_d = 8'h01 << win_rel[2:0];
            sel_d   = win_rel[2:0];
            hold_d  = '0;
          end else begin
            state_d = S_IDLE;
            grant_d = 8'h00;
            hold_d  = '0;
          end
        end else begin
          // Owner keeps the mux. With MAX_HOLD=0 the count saturates.
          if (hold_q != CNT_MAX) begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 8'h00;
        hold_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;   // requester 0 gets top priority after reset
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign grant_valid = |grant_q;
  assign hold_cnt    = hold_q;
  assign dbg_state   = state_q;
  assign dbg_last    = last_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//
// Two arbiter instances share clock, reset, en and req: one with the default
// hold limit (16) and one with MAX_HOLD=4 for the timeout scenarios. use4
// picks which instance's outputs are compared at each step.
// Each step drives inputs on the falling edge, pushes the expected outputs
// after the next rising edge onto exp_q, then pops and compares 1 time unit
// after that rising edge.
// -----------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       use4 = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] grant16, grant4;
  logic [2:0] sel16, sel4;
  logic       gv16, gv4;
  logic [4:0] hold16;
  logic [2:0] hold4;
  logic       st16, st4;
  logic [2:0] last16, last4;

  mux8_rr_arbiter dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .grant      (grant16),
    .sel        (sel16),
    .grant_valid(gv16),
    .hold_cnt   (hold16),
    .dbg_state  (st16),
    .dbg_last   (last16)
  );

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .grant      (grant4),
    .sel        (sel4),
    .grant_valid(gv4),
    .hold_cnt   (hold4),
    .dbg_state  (st4),
    .dbg_last   (last4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  // Packed as {grant[7:0], sel[2:0], grant_valid, hold_cnt[4:0]}.
  logic [16:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [16:0] observed();
    if (use4) return {grant4, sel4, gv4, {2'b00, hold4}};
    else      return {grant16, sel16, gv16, hold16};
  endfunction

  task automatic check(input string name);
    logic [16:0] act;
    logic [16:0] exp;
    act = observed();
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        bad++;
        $display("FAIL %s: got grant=%h sel=%0d valid=%b hold=%0d, want grant=%h sel=%0d valid=%b hold=%0d",
                 name, act[16:9], act[8:6], act[5], act[4:0],
                 exp[16:9], exp[8:6], exp[5], exp[4:0]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic e, input logic [7:0] rq,
                      input logic u4, input logic [7:0] eg,
                      input logic [2:0] es, input logic [4:0] eh,
                      input string name);
    @(negedge clk);
    rst_n = r;
    en    = e;
    req   = rq;
    use4  = u4;
    exp_q.push_back({eg, es, |eg, eh});
    @(posedge clk);
    #1;
    check(name);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table (default-hold instance)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic [4:0] hold;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] rq,
                              input logic [7:0] g, input logic [2:0] s,
                              input logic [4:0] h);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = rq; v.grant = g; v.sel = s; v.hold = h;
    return v;
  endfunction

  initial begin
    // Reset with all requests high, then requester 0 wins first.
    tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 3'd0, 5'd0));
    tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 3'd0, 5'd0));
    tbl.push_back(mk(1, 1, 8'hFF, 8'h01, 3'd0, 5'd0));
    // Owner 0 drops, nobody else -> idle, sel holds.
    tbl.push_back(mk(1, 1, 8'h00, 8'h00, 3'd0, 5'd0));
    // Single requester 3 for five edges, hold 0..4, then drop.
    tbl.push_back(mk(1, 1, 8'h08, 8'h08, 3'd3, 5'd0));
    tbl.push_back(mk(1, 1, 8'h08, 8'h08, 3'd3, 5'd1));
    tbl.push_back(mk(1, 1, 8'h08, 8'h08, 3'd3, 5'd2));
    tbl.push_back(mk(1, 1, 8'h08, 8'h08, 3'd3, 5'd3));
    tbl.push_back(mk(1, 1, 8'h08, 8'h08, 3'd3, 5'd4));
    tbl.push_back(mk(1, 1, 8'h00, 8'h00, 3'd3, 5'd0));
    // Pointer=3: requester 1 wins; requester 0 arriving does not pre-empt.
    tbl.push_back(mk(1, 1, 8'h02, 8'h02, 3'd1, 5'd0));
    tbl.push_back(mk(1, 1, 8'h03, 8'h02, 3'd1, 5'd1));
    // Owner 1 drops while 0 waits -> back-to-back switch to 0.
    tbl.push_back(mk(1, 1, 8'h01, 8'h01, 3'd0, 5'd0));
    // Switch to owner 2, then disable for three cycles.
    tbl.push_back(mk(1, 1, 8'h04, 8'h04, 3'd2, 5'd0));
    tbl.push_back(mk(1, 1, 8'h04, 8'h04, 3'd2, 5'd1));
    tbl.push_back(mk(1, 0, 8'h04, 8'h00, 3'd2, 5'd0));
    tbl.push_back(mk(1, 0, 8'h04, 8'h00, 3'd2, 5'd0));
    tbl.push_back(mk(1, 0, 8'h06, 8'h00, 3'd2, 5'd0));
    // Re-enable: pointer=2, scan 3..7,0,1 -> requester 1.
    tbl.push_back(mk(1, 1, 8'h06, 8'h02, 3'd1, 5'd0));
    // Move to owner 5, then reset mid-grant.
    tbl.push_back(mk(1, 1, 8'h20, 8'h20, 3'd5, 5'd0));
    tbl.push_back(mk(1, 1, 8'h20, 8'h20, 3'd5, 5'd1));
    tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 3'd0, 5'd0));
    tbl.push_back(mk(1, 1, 8'hFF, 8'h01, 3'd0, 5'd0));
    // Owner 7 with 0 also requesting; drop 7 -> wrap to 0.
    tbl.push_back(mk(1, 1, 8'h80, 8'h80, 3'd7, 5'd0));
    tbl.push_back(mk(1, 1, 8'h81, 8'h80, 3'd7, 5'd1));
    tbl.push_back(mk(1, 1, 8'h01, 8'h01, 3'd0, 5'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].req, 1'b0,
           tbl[i].grant, tbl[i].sel, tbl[i].hold, $sformatf("vec%0d", i));
    end

    // -------------------------------------------------------------------------
    // MAX_HOLD=4, all requesting: each owner holds exactly 4 cycles, no gaps.
    // -------------------------------------------------------------------------
    step(0, 1, 8'hFF, 1'b1, 8'h00, 3'd0, 5'd0, "rst4");
    for (int k = 0; k < 36; k++) begin
      int       o;
      logic [7:0] g;
      o = (k / 4) % 8;
      g = 8'h01 << o;
      step(1, 1, 8'hFF, 1'b1, g, 3'(o), 5'(k % 4), $sformatf("rr4_%0d", k));
    end

    // -------------------------------------------------------------------------
    // MAX_HOLD=4, sole requester 7 times out and is re-granted with hold=0;
    // then a timeout with requester 0 waiting wraps to 0.
    // -------------------------------------------------------------------------
    step(0, 1, 8'h80, 1'b1, 8'h00, 3'd0, 5'd0, "to_rst");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd0, "to_g0");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd1, "to_g1");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd2, "to_g2");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd3, "to_g3");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd0, "to_regrant");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd1, "to_r1");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd2, "to_r2");
    step(1, 1, 8'h80, 1'b1, 8'h80, 3'd7, 5'd3, "to_r3");
    step(1, 1, 8'h81, 1'b1, 8'h01, 3'd0, 5'd0, "to_wrap");

    // -------------------------------------------------------------------------
    // Report
    // -------------------------------------------------------------------------
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expected entries not consumed, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
